// File: rtl/vrf_read_responder.sv
// vrf_read_responder: read-stream responder for the vector register file.
// Accepts per-beat read requests, performs a registered array read (S1) and
// returns byte-masked beats in order through a 3-entry output FIFO. Also owns
// the byte-writable write port used by write-back.
// Optional feature: define VRF_BYPASS_EN to forward a same-cycle write to a
// read of the same address (written bytes replace the old ones).
module vrf_read_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    input  logic [DATA_WIDTH/8-1:0]   rd_ben,
    input  logic                      rd_start,
    input  logic                      rd_end,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [DATA_WIDTH/8-1:0]   out_ben,
    output logic                      out_start,
    output logic                      out_end,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_ben
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int FDEP  = 3;

    // Zero every byte whose enable is clear.
    function automatic logic [DATA_WIDTH-1:0] mask_bytes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [NB-1:0]         ben);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            if (ben[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    // Modulo-3 pointer advance.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Register file storage (not reset).
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // S1 read stage.
    logic                  s1_v_q,     s1_v_d;
    logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [NB-1:0]         s1_ben_q,   s1_ben_d;
    logic                  s1_start_q, s1_start_d;
    logic                  s1_end_q,   s1_end_d;

    // Output FIFO.
    logic [DATA_WIDTH-1:0] fifo_data_q  [FDEP];
    logic [DATA_WIDTH-1:0] fifo_data_d  [FDEP];
    logic [NB-1:0]         fifo_ben_q   [FDEP];
    logic [NB-1:0]         fifo_ben_d   [FDEP];
    logic                  fifo_start_q [FDEP];
    logic                  fifo_start_d [FDEP];
    logic                  fifo_end_q   [FDEP];
    logic                  fifo_end_d   [FDEP];
    logic [1:0]            wr_ptr_q,   wr_ptr_d;
    logic [1:0]            rd_ptr_q,   rd_ptr_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    logic       accept;
    logic       push;
    logic       pop;
    logic [2:0] occ;

    // Ready depends only on registered occupancy (S1 plus FIFO).
    assign occ       = {1'b0, fifo_cnt_q} + {2'b00, s1_v_q};
    assign rd_ready  = (occ < 3'd3);
    assign accept    = rd_valid & rd_ready;
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign push      = s1_v_q;
    assign pop       = out_valid & out_ready;

    // Head of FIFO drives the outputs; gated so an empty FIFO presents zeros.
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q]  : '0;
    assign out_ben   = out_valid ? fifo_ben_q[rd_ptr_q]   : '0;
    assign out_start = out_valid ? fifo_start_q[rd_ptr_q] : 1'b0;
    assign out_end   = out_valid ? fifo_end_q[rd_ptr_q]   : 1'b0;

    // Byte-enabled array write, independent of read flow control.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_ben[i]) mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // S1 next state: load the array word and beat attributes on accept.
    always_comb begin
        s1_v_d     = accept;
        s1_data_d  = s1_data_q;
        s1_ben_d   = s1_ben_q;
        s1_start_d = s1_start_q;
        s1_end_d   = s1_end_q;
        if (accept) begin
            s1_data_d  = mem_q[rd_addr];
`ifdef VRF_BYPASS_EN
            // Same-cycle write to the same address: take the newly written bytes.
            if (wr_en && (wr_addr == rd_addr)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_ben[i]) s1_data_d[i*8 +: 8] = wr_data[i*8 +: 8];
                end
            end
`endif
            s1_ben_d   = rd_ben;
            s1_start_d = rd_start;
            s1_end_d   = rd_end;
        end
    end

    // FIFO next state: push the masked S1 beat, pop on consumer handshake.
    always_comb begin
        fifo_data_d  = fifo_data_q;
        fifo_ben_d   = fifo_ben_q;
        fifo_start_d = fifo_start_q;
        fifo_end_d   = fifo_end_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        if (push) begin
            fifo_data_d[wr_ptr_q]  = mask_bytes(s1_data_q, s1_ben_q);
            fifo_ben_d[wr_ptr_q]   = s1_ben_q;
            fifo_start_d[wr_ptr_q] = s1_start_q;
            fifo_end_d[wr_ptr_q]   = s1_end_q;
            wr_ptr_d               = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Control state: cleared by reset, which discards in-flight beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 2'd0;
        end else begin
            s1_v_q     <= s1_v_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Datapath payload registers: qualified by the control flags, never reset.
    always_ff @(posedge clk) begin
        s1_data_q    <= s1_data_d;
        s1_ben_q     <= s1_ben_d;
        s1_start_q   <= s1_start_d;
        s1_end_q     <= s1_end_d;
        fifo_data_q  <= fifo_data_d;
        fifo_ben_q   <= fifo_ben_d;
        fifo_start_q <= fifo_start_d;
        fifo_end_q   <= fifo_end_d;
    end

endmodule

// File: tb/tb_vrf_read_responder.sv
// Testbench for vrf_read_responder: directed cases plus randomized traffic,
// checked against a queue-based reference model of the read stream.
module tb_vrf_read_responder;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int NB = DW / 8;

`ifdef VRF_BYPASS_EN
    localparam logic [DW-1:0] BYP_EXP = {DW{1'b1}};
`else
    localparam logic [DW-1:0] BYP_EXP = '0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [NB-1:0] rd_ben;
    logic          rd_start;
    logic          rd_end;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [NB-1:0] out_ben;
    logic          out_start;
    logic          out_end;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_ben;

    vrf_read_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_ben(rd_ben),
        .rd_start(rd_start), .rd_end(rd_end),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ben(out_ben),
        .out_start(out_start), .out_end(out_end),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ben(wr_ben)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] ben;
        logic          st;
        logic          en;
        int            acc;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] mdl_mem [1 << AW];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_pop = 0;
    int first_pop = -1;
    int last_pop = -1;
    int low_cnt = 0;

    logic          stall_prev = 1'b0;
    logic [DW-1:0] hold_data;
    logic [NB-1:0] hold_ben;
    logic          hold_st;
    logic          hold_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: called just after a falling edge with inputs already
    // driven; checks outputs against the model, updates the model with what
    // the coming rising edge does, then waits for the next falling edge.
    task automatic tick();
        beat_t b;
        logic  exp_v;
        #1;
        exp_v = 1'b0;
        if (exp_q.size() > 0) begin
            if (exp_q[0].acc <= cyc - 2) exp_v = 1'b1;
        end
        check("out_valid", out_valid, exp_v);
        check("rd_ready", rd_ready, (exp_q.size() < 3));
        if (!rd_ready) low_cnt++;
        if (stall_prev) begin
            check("stall_data", out_data, hold_data);
            check("stall_ben", out_ben, hold_ben);
            check("stall_start", out_start, hold_st);
            check("stall_end", out_end, hold_en);
        end
        stall_prev = out_valid && !out_ready;
        hold_data  = out_data;
        hold_ben   = out_ben;
        hold_st    = out_start;
        hold_en    = out_end;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", out_data, b.data);
                check("beat_ben", out_ben, b.ben);
                check("beat_start", out_start, b.st);
                check("beat_end", out_end, b.en);
            end
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (rd_valid && rd_ready) begin
            b.data = mdl_mem[rd_addr];
`ifdef VRF_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) begin
                for (int i = 0; i < NB; i++) if (wr_ben[i]) b.data[i*8 +: 8] = wr_data[i*8 +: 8];
            end
`endif
            for (int i = 0; i < NB; i++) if (!rd_ben[i]) b.data[i*8 +: 8] = 8'h00;
            b.ben = rd_ben;
            b.st  = rd_start;
            b.en  = rd_end;
            b.acc = cyc;
            exp_q.push_back(b);
        end
        if (wr_en) begin
            for (int i = 0; i < NB; i++) if (wr_ben[i]) mdl_mem[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
        end
        cyc++;
        @(negedge clk);
    endtask

    // Offer n beats at addresses base.., holding out_ready low for 'hold' cycles.
    task automatic burst(input int base, input int n, input int hold);
        int sent;
        int c;
        sent = 0;
        c = 0;
        while ((sent < n || exp_q.size() > 0) && c < 300) begin
            if (hold > 0 && c == hold) begin
                check("bp_accepts", sent, 3);
                check("bp_rd_ready", rd_ready, 0);
            end
            out_ready = (c >= hold);
            if (sent < n) begin
                rd_valid = 1'b1;
                rd_addr  = AW'(base + sent);
                rd_ben   = '1;
                rd_start = (sent == 0);
                rd_end   = (sent == n - 1);
            end else begin
                rd_valid = 1'b0;
            end
            if (sent < n && rd_ready) sent++;
            tick();
            c++;
        end
        rd_valid = 1'b0;
        check("burst_done", (c < 300), 1);
    endtask

    initial begin
        int acc_n;
        int c;
        logic will_acc;

        rst = 1'b1; rd_valid = 1'b0; rd_addr = '0; rd_ben = '0; rd_start = 1'b0; rd_end = 1'b0;
        out_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_ben = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_rd_ready", rd_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ben", out_ben, 0);
        check("rst_out_start", out_start, 0);
        check("rst_out_end", out_end, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill the whole array with known contents (address 9 holds zero)
        for (int a = 0; a < (1 << AW); a++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(a);
            wr_data = (a == 9) ? '0 : {$urandom, $urandom};
            wr_ben  = '1;
            tick();
        end
        wr_en = 1'b0;

        // Write then masked read of beat 5
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 64'h0123_4567_89AB_CDEF; wr_ben = 8'hFF;
        tick();
        wr_en = 1'b0;
        rd_valid = 1'b1; rd_addr = 8'd5; rd_ben = 8'h0F; rd_start = 1'b1; rd_end = 1'b1;
        out_ready = 1'b1;
        tick();
        rd_valid = 1'b0;
        tick();
        #1;
        check("mask_valid", out_valid, 1);
        check("mask_data", out_data, 64'h0000_0000_89AB_CDEF);
        check("mask_ben", out_ben, 8'h0F);
        tick();
        tick();

        // Full-throughput burst
        low_cnt = 0; n_pop = 0; first_pop = -1; last_pop = -1;
        burst(0, 8, 0);
        check("tp_pops", n_pop, 8);
        check("tp_span", last_pop - first_pop, 7);
        check("tp_rdy_low", low_cnt, 0);

        // Backpressured burst
        n_pop = 0;
        burst(0, 8, 10);
        check("bp_pops", n_pop, 8);

        // Same-cycle write and read of address 9
        out_ready = 1'b1;
        rd_valid = 1'b1; rd_addr = 8'd9; rd_ben = 8'hFF; rd_start = 1'b1; rd_end = 1'b1;
        wr_en = 1'b1; wr_addr = 8'd9; wr_data = '1; wr_ben = 8'hFF;
        tick();
        rd_valid = 1'b0; wr_en = 1'b0;
        tick();
        #1;
        check("rdw_data", out_data, BYP_EXP);
        tick();
        tick();

        // Reset with two beats buffered
        out_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 8'd1; rd_ben = 8'hFF; rd_start = 1'b1; rd_end = 1'b0;
        tick();
        rd_addr = 8'd2; rd_start = 1'b0; rd_end = 1'b1;
        tick();
        rd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_rd_ready", rd_ready, 1);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        rd_valid = 1'b1; rd_addr = 8'd5; rd_ben = 8'hFF; rd_start = 1'b1; rd_end = 1'b1;
        tick();
        rd_valid = 1'b0;
        tick();
        #1;
        check("post_rst_data", out_data, 64'h0123_4567_89AB_CDEF);
        tick();
        tick();

        // Random traffic with random backpressure and colliding writes
        acc_n = 0;
        c = 0;
        rd_valid = 1'b0;
        while ((acc_n < 1000 || exp_q.size() > 0) && c < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!rd_valid && acc_n < 1000 && $urandom_range(0, 3) != 0) begin
                rd_valid = 1'b1;
                rd_addr  = AW'($urandom_range(0, 15));
                rd_ben   = NB'($urandom);
                rd_start = 1'($urandom);
                rd_end   = 1'($urandom);
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = {$urandom, $urandom};
            wr_ben  = NB'($urandom);
            will_acc = rd_valid && rd_ready;
            tick();
            c++;
            if (will_acc) begin
                acc_n++;
                rd_valid = 1'b0;
            end
        end
        wr_en = 1'b0;
        check("rnd_done", (c < 20000), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
